multicycle_control_unit: RTL and testbench

- Next-generation RV32I controller for the multi-cycle core variant.
- Replaces the purely combinational single-cycle controller with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds a memory-ready handshake, an instruction-retired pulse and an illegal-opcode flag.
- ALU-control width and the extended ALU operation set are parametrised.

---
 rtl/multicycle_control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over one shared ALU and one memory port.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter bit EXT_OPS    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  instr_done,
  output logic                  illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        w_pc_update;
  logic        w_branch;
  logic        w_adr_src;
  logic        w_ir_write;
  logic        w_mem_write;
  logic        w_reg_write;
  logic [1:0]  w_result_src;
  logic [1:0]  w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic        w_done;
  logic        w_illegal;
  logic [1:0]  w_imm_src;
  logic [2:0]  w_alu_ctrl;
  logic        w_unused_funct7;

  // Only funct7[5] distinguishes add/sub; the remaining bits are ignored.
  assign w_unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  // Main ALU decoder: ALUOp plus funct fields to a 3-bit operation code.
  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7b5);
    logic [2:0] r;
    r = 3'b000;
    case (alu_op)
      2'b00: r = 3'b000;
      2'b01: r = 3'b001;
      2'b10: begin
        case (f3)
          3'b000: begin
            if (op5 && f7b5) r = 3'b001;
            else             r = 3'b000;
          end
          3'b010: r = 3'b101;
          3'b110: r = 3'b011;
          3'b111: r = 3'b010;
          3'b100: begin
            if (EXT_OPS) r = 3'b100;
            else         r = 3'b000;
          end
          3'b011: begin
            if (EXT_OPS) r = 3'b110;
            else         r = 3'b000;
          end
          default: r = 3'b000;
        endcase
      end
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // State register; reset restarts the sequence from FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unreachable encodings fall back to FETCH.
  always_comb begin
    w_next_state = FETCH;
    case (r_state)
      FETCH: begin
        if (mem_ready) w_next_state = DECODE;
        else           w_next_state = FETCH;
      end
      DECODE: begin
        case (Op)
          OP_LW:   w_next_state = MEMADR;
          OP_SW:   w_next_state = MEMADR;
          OP_R:    w_next_state = EXECUTER;
          OP_I:    w_next_state = EXECUTEI;
          OP_BEQ:  w_next_state = BEQ;
          OP_JAL:  w_next_state = JAL;
          default: w_next_state = FETCH;
        endcase
      end
      MEMADR: begin
        if (Op == OP_SW) w_next_state = MEMWRITE;
        else             w_next_state = MEMREAD;
      end
      MEMREAD: begin
        if (mem_ready) w_next_state = MEMWB;
        else           w_next_state = MEMREAD;
      end
      MEMWRITE: begin
        if (mem_ready) w_next_state = FETCH;
        else           w_next_state = MEMWRITE;
      end
      MEMWB:    w_next_state = FETCH;
      EXECUTER: w_next_state = ALUWB;
      EXECUTEI: w_next_state = ALUWB;
      ALUWB:    w_next_state = FETCH;
      BEQ:      w_next_state = FETCH;
      JAL:      w_next_state = ALUWB;
      default:  w_next_state = FETCH;
    endcase
  end

  // Per-state Moore outputs; mem_ready only qualifies the memory handshake.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_done       = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
      end
      DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (Op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: w_illegal = 1'b0;
          default:                                   w_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      MEMREAD: begin
        w_adr_src = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = mem_ready;
      end
      MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: begin
        w_pc_update = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode every cycle, independent of state.
  always_comb begin
    w_imm_src = 2'b00;
    case (Op)
      OP_LW:   w_imm_src = 2'b00;
      OP_I:    w_imm_src = 2'b00;
      OP_SW:   w_imm_src = 2'b01;
      OP_BEQ:  w_imm_src = 2'b10;
      OP_JAL:  w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  assign w_alu_ctrl = alu_decode(w_alu_op, funct3, Op[5], funct7[5]);

  // Enables are held low while reset is asserted; selects keep FETCH values.
  assign PCWrite    = rst & (w_pc_update | (w_branch & Zero));
  assign IRWrite    = rst & w_ir_write;
  assign MemWrite   = rst & w_mem_write;
  assign RegWrite   = rst & w_reg_write;
  assign instr_done = rst & w_done;
  assign illegal_op = rst & w_illegal;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign ImmSrc     = w_imm_src;
  assign ALUControl = ALU_CTRL_W'(w_alu_ctrl);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (default params).
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        instr_done, illegal_op;
  logic [17:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_unit #(.ALU_CTRL_W(3), .EXT_OPS(1'b1)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector, same field order as obs.
  function automatic logic [17:0] v(input logic pcw, input logic adr,
                                    input logic irw, input logic mw,
                                    input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] imm, input logic [2:0] alu,
                                    input logic done, input logic ill);
    return {pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, done, ill};
  endfunction

  function automatic logic [17:0] e_fetch(input logic [1:0] imm);
    return v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] e_decode(input logic [1:0] imm);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick(input string tag, input logic [17:0] e);
    #1;
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rt_f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001};
  logic [6:0] rt_f7  [8] = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000,
                             7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  logic [2:0] rt_alu [8] = '{3'b001, 3'b000, 3'b100, 3'b011, 3'b010, 3'b101, 3'b110, 3'b000};

  initial begin
    rst = 1'b1; Op = 7'b0000011; funct3 = 3'b000; funct7 = 7'b0000000;
    Zero = 1'b0; mem_ready = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // Reset held with mem_ready=1: enables low, FETCH selects
    for (int i = 0; i < 3; i++)
      tick("reset", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0));
    rst = 1'b1;

    // lw, mem_ready=1 throughout: 5 cycles
    tick("lw_fetch", e_fetch(2'b00));
    tick("lw_decode", e_decode(2'b00));
    tick("lw_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
    tick("lw_memread", v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
    tick("lw_memwb", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));

    // sw with a FETCH stall and two MEMWRITE wait cycles
    Op = 7'b0100011; mem_ready = 1'b0;
    tick("sw_fetch_wait", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0));
    mem_ready = 1'b1;
    tick("sw_fetch", e_fetch(2'b01));
    tick("sw_decode", e_decode(2'b01));
    tick("sw_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0));
    mem_ready = 1'b0;
    tick("sw_memwr_wait1", v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0));
    tick("sw_memwr_wait2", v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0));
    mem_ready = 1'b1;
    tick("sw_memwr_ready", v(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0));

    // R-type ALU decode table: 4 cycles each
    Op = 7'b0110011;
    for (int i = 0; i < 8; i++) begin
      funct3 = rt_f3[i]; funct7 = rt_f7[i];
      tick("r_fetch", e_fetch(2'b00));
      tick("r_decode", e_decode(2'b00));
      tick("r_execute", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, rt_alu[i], 1'b0, 1'b0));
      tick("r_aluwb", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));
    end

    // I-type with funct7[5]=1: Op[5]=0 keeps it an add
    Op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
    tick("i_fetch", e_fetch(2'b00));
    tick("i_decode", e_decode(2'b00));
    tick("i_execute", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
    tick("i_aluwb", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));

    // beq taken, then not taken
    Op = 7'b1100011; funct7 = 7'b0000000; Zero = 1'b1;
    tick("beq_fetch", e_fetch(2'b10));
    tick("beq_decode", e_decode(2'b10));
    tick("beq_taken", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b1, 1'b0));
    Zero = 1'b0;
    tick("beq_fetch2", e_fetch(2'b10));
    tick("beq_decode2", e_decode(2'b10));
    tick("beq_not_taken", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b1, 1'b0));

    // jal: 4 cycles
    Op = 7'b1101111;
    tick("jal_fetch", e_fetch(2'b11));
    tick("jal_decode", e_decode(2'b11));
    tick("jal_jal", v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0, 1'b0));
    tick("jal_aluwb", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b1, 1'b0));

    // Illegal opcode: pulse in DECODE, back to FETCH
    Op = 7'b1111111;
    tick("ill_fetch", e_fetch(2'b00));
    tick("ill_decode", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 1'b1));
    tick("ill_refetch", e_fetch(2'b00));
    tick("ill_decode2", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 1'b1));

    // Asynchronous reset while waiting in MEMREAD
    Op = 7'b0000011;
    tick("ar_fetch", e_fetch(2'b00));
    tick("ar_decode", e_decode(2'b00));
    tick("ar_memadr", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
    mem_ready = 1'b0;
    tick("ar_memread", v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
    rst = 1'b0; mem_ready = 1'b1;
    tick("ar_in_reset", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0));
    rst = 1'b1;
    tick("ar_restart", e_fetch(2'b00));
    tick("ar_decode2", e_decode(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
